ti_adc_offset_cal: RTL and testbench

// Background per-slice offset estimation and correction for the time-interleaved ADC.

---
 rtl/ti_adc_offset_cal.sv | 147 ++++++++++++++
 tb/tb_ti_adc_offset_cal.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ti_adc_offset_cal.sv
// Background per-slice DC offset estimation (mean of 2^Nacc samples) and
// saturating offset correction for the time-interleaved ADC slices.

module ti_adc_offset_cal_lane #(
   parameter int Nadc = 8,
   parameter int Nacc = 10
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            acc_clr_i,
   input  logic            acc_add_i,
   input  logic            ofs_upd_i,
   input  logic [Nadc-1:0] din_i,
   output logic [Nadc-1:0] dout_o,
   output logic [Nadc-1:0] ofs_o
);
   localparam int AW = Nadc + Nacc;

   // acc, ofs and dout hold two's complement values
   logic [AW-1:0]   acc_q, acc_d;
   logic [Nadc-1:0] ofs_q, ofs_d;
   logic [Nadc-1:0] dout_q, dout_d;
   logic [Nadc:0]   diff;

   always_comb begin
      diff = {din_i[Nadc-1], din_i} - {ofs_q[Nadc-1], ofs_q};
      if (diff[Nadc] != diff[Nadc-1])
         dout_d = diff[Nadc] ? {1'b1, {(Nadc-1){1'b0}}} : {1'b0, {(Nadc-1){1'b1}}};
      else
         dout_d = diff[Nadc-1:0];
   end

   always_comb begin
      acc_d = acc_q;
      if (acc_clr_i)
         acc_d = '0;
      else if (acc_add_i)
         acc_d = acc_q + {{Nacc{din_i[Nadc-1]}}, din_i};
   end

   // Round half up: (acc + 2^(Nacc-1)) >>> Nacc equals the upper slice plus
   // the bit just below the binary point.
   always_comb begin
      ofs_d = ofs_q;
      if (ofs_upd_i)
         ofs_d = acc_q[AW-1:Nacc] + {{(Nadc-1){1'b0}}, acc_q[Nacc-1]};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_q  <= '0;
         ofs_q  <= '0;
         dout_q <= '0;
      end else begin
         acc_q  <= acc_d;
         ofs_q  <= ofs_d;
         dout_q <= dout_d;
      end
   end

   assign dout_o = dout_q;
   assign ofs_o  = ofs_q;
endmodule

module ti_adc_offset_cal #(
   parameter int Nadc = 8,
   parameter int Nti  = 5,
   parameter int Nacc = 10
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      en,
   input  logic [Nti-1:0][Nadc-1:0]  din,
   output logic [Nti-1:0][Nadc-1:0]  dout,
   output logic [Nti-1:0][Nadc-1:0]  ofs,
   output logic                      cal_done
);
   typedef enum logic [1:0] {IDLE, ACC, UPD} state_t;

   state_t          state_q, state_d;
   logic [Nacc-1:0] cnt_q, cnt_d;
   logic            cal_done_q, cal_done_d;
   logic            acc_clr, acc_add, ofs_upd;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_clr = 1'b1;
      acc_add = 1'b0;
      ofs_upd = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (en) state_d = ACC;
         end
         ACC: begin
            if (en) begin
               acc_clr = 1'b0;
               acc_add = 1'b1;
               cnt_d   = cnt_q + Nacc'(1);
               if (cnt_q == '1) state_d = UPD;
            end else begin
               // abort: partial window dropped, previous ofs kept
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         UPD: begin
            ofs_upd = 1'b1;
            cnt_d   = '0;
            state_d = en ? ACC : IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      cal_done_d = ofs_upd;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cal_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cal_done_q <= cal_done_d;
      end
   end

   assign cal_done = cal_done_q;

   for (genvar i = 0; i < Nti; i++) begin : g_lane
      ti_adc_offset_cal_lane #(.Nadc(Nadc), .Nacc(Nacc)) u_lane (
         .clk       (clk),
         .rstn      (rstn),
         .acc_clr_i (acc_clr),
         .acc_add_i (acc_add),
         .ofs_upd_i (ofs_upd),
         .din_i     (din[i]),
         .dout_o    (dout[i]),
         .ofs_o     (ofs[i])
      );
   end
endmodule

// File: tb/tb_ti_adc_offset_cal.sv
// Bench for ti_adc_offset_cal: vector tables, hand-written corner sequences and
// randomized traffic against a window-level reference model.

module tb_ti_adc_offset_cal;
   localparam int NADC = 8;
   localparam int NTI  = 5;
   localparam int NACC = 4;
   localparam int WIN  = 1 << NACC;
   localparam int PER  = WIN + 1;

   typedef struct {
      int din [NTI];
      int exp [NTI];
   } vec_t;

   logic clk = 1'b0;
   logic rstn = 1'b1;
   logic en = 1'b0;
   logic [NTI-1:0][NADC-1:0] din = '0;
   logic [NTI-1:0][NADC-1:0] dout, ofs;
   logic cal_done;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: window position counted in en=1 edges since leaving idle
   int ofs_m [NTI];
   int sum_m [NTI];
   int dout_m[NTI];
   int run_m;
   bit cd_m;

   always #5 clk = ~clk;

   ti_adc_offset_cal #(.Nadc(NADC), .Nti(NTI), .Nacc(NACC)) dut (
      .clk(clk), .rstn(rstn), .en(en), .din(din),
      .dout(dout), .ofs(ofs), .cal_done(cal_done)
   );

   function automatic int sat(input int v);
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   function automatic int fdiv(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   function automatic logic [NTI*NADC-1:0] pack(input int v[NTI]);
      logic [NTI*NADC-1:0] r;
      r = '0;
      for (int i = 0; i < NTI; i++) r[i*NADC +: NADC] = v[i][NADC-1:0];
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%h exp=%h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      run_m = 0;
      cd_m  = 0;
      for (int i = 0; i < NTI; i++) begin
         ofs_m[i] = 0; sum_m[i] = 0; dout_m[i] = 0;
      end
   endtask

   task automatic model_edge(input bit e, input int d[NTI]);
      int p;
      for (int i = 0; i < NTI; i++) dout_m[i] = sat(d[i] - ofs_m[i]);
      cd_m = 0;
      if (run_m == 0) begin
         if (e) run_m = 1;
      end else begin
         p = (run_m - 1) % PER;
         if (p < WIN) begin
            if (e) begin
               for (int i = 0; i < NTI; i++) sum_m[i] += d[i];
               run_m++;
            end else begin
               run_m = 0;
               for (int i = 0; i < NTI; i++) sum_m[i] = 0;
            end
         end else begin
            for (int i = 0; i < NTI; i++) begin
               ofs_m[i] = fdiv(sum_m[i] + WIN/2, WIN);
               sum_m[i] = 0;
            end
            cd_m  = 1;
            run_m = e ? run_m + 1 : 0;
         end
      end
   endtask

   task automatic step(input bit e, input int d[NTI]);
      en  = e;
      din = pack(d);
      @(posedge clk);
      model_edge(e, d);
      #1;
      check("dout", dout, pack(dout_m));
      check("ofs", ofs, pack(ofs_m));
      check("cal_done", {63'd0, cal_done}, {63'd0, cd_m});
   endtask

   task automatic do_reset();
      #2 rstn = 1'b0;
      en = 1'b0;
      model_reset();
      #1;
      check("rst_dout", dout, '0);
      check("rst_ofs", ofs, '0);
      check("rst_cal_done", {63'd0, cal_done}, 64'd0);
      #2 rstn = 1'b1;
   endtask

   task automatic run_to_done(input int d[NTI], output int edges);
      edges = -1;
      for (int k = 1; k <= 3 * PER; k++) begin
         step(1'b1, d);
         if (cal_done === 1'b1) begin
            edges = k;
            break;
         end
      end
   endtask

   vec_t tbl1[4];
   vec_t tbl4[4];

   initial begin
      int n;
      int cd_seen;
      int d2[NTI], d5[NTI], d5b[NTI], d4[NTI], dz[NTI], dr[NTI], zero5[NTI];

      tbl1[0].din = '{10, -3, 0, 127, -128};   tbl1[0].exp = '{10, -3, 0, 127, -128};
      tbl1[1].din = '{-1, 1, 64, -64, 5};      tbl1[1].exp = '{-1, 1, 64, -64, 5};
      tbl1[2].din = '{127, 127, -128, -128, 0}; tbl1[2].exp = '{127, 127, -128, -128, 0};
      tbl1[3].din = '{0, 0, 0, 0, 0};          tbl1[3].exp = '{0, 0, 0, 0, 0};
      tbl4[0].din = '{-128, 127, 0, 0, 0};     tbl4[0].exp = '{-128, 127, 0, 0, 0};
      tbl4[1].din = '{10, -3, 100, -100, 1};   tbl4[1].exp = '{5, 2, 100, -100, 1};
      tbl4[2].din = '{127, -128, -1, 1, 0};    tbl4[2].exp = '{122, -123, -1, 1, 0};
      tbl4[3].din = '{-124, 124, 50, -50, 7};  tbl4[3].exp = '{-128, 127, 50, -50, 7};

      d2    = '{3, -2, 0, 7, -5};
      d5    = '{20, 20, 20, 20, 20};
      d5b   = '{1, 2, 3, 4, 5};
      d4    = '{5, -5, 0, 0, 0};
      zero5 = '{0, 0, 0, 0, 0};

      // 1: pass-through with zero offset, cal_done idle
      do_reset();
      for (int t = 0; t < 4; t++) begin
         step(1'b0, tbl1[t].din);
         check("s1_dout", dout, pack(tbl1[t].exp));
      end

      // 2: constant input calibrates to itself
      do_reset();
      run_to_done(d2, n);
      check("s2_first_latency", n, 18);
      check("s2_ofs", ofs, pack(d2));
      step(1'b1, d2);
      check("s2_dout_zero", dout, '0);
      run_to_done(d2, n);
      check("s2_period", n + 1, 17);
      step(1'b0, d2);
      step(1'b0, d2);

      // 5: abort at cnt=9 keeps ofs, re-enable starts a fresh window
      step(1'b1, d5);
      for (int k = 0; k < 9; k++) step(1'b1, d5);
      step(1'b0, d5);
      cd_seen = 0;
      for (int k = 0; k < 20; k++) begin
         step(1'b0, d5);
         if (cal_done === 1'b1) cd_seen++;
      end
      check("s5_no_done", cd_seen, 0);
      check("s5_ofs_kept", ofs, pack(d2));
      run_to_done(d5b, n);
      check("s5_fresh_latency", n, 18);
      check("s5_fresh_ofs", ofs, pack(d5b));

      // 3: rounding of +0.5 and -0.5
      do_reset();
      for (int k = 1; k <= 17; k++) begin
         dz = '{k % 2, -(k % 2), 0, 0, 0};
         step(1'b1, dz);
      end
      step(1'b0, zero5);
      check("s3_done", {63'd0, cal_done}, 64'd1);
      check("s3_ofs0", int'($signed(ofs[0])), 1);
      check("s3_ofs1", int'($signed(ofs[1])), 0);

      // 4: saturation of the corrected output
      do_reset();
      for (int k = 1; k <= 17; k++) step(1'b1, d4);
      step(1'b0, d4);
      check("s4_ofs", ofs, pack(d4));
      for (int t = 0; t < 4; t++) begin
         step(1'b0, tbl4[t].din);
         check("s4_dout", dout, pack(tbl4[t].exp));
      end

      // 6: async reset mid-ACC and during UPD
      do_reset();
      for (int k = 0; k < 8; k++) step(1'b1, d2);
      do_reset();
      for (int k = 1; k <= 17; k++) step(1'b1, d2);
      do_reset();
      cd_seen = 0;
      for (int k = 0; k < 20; k++) begin
         step(1'b0, d2);
         if (cal_done === 1'b1) cd_seen++;
      end
      check("s6_no_done", cd_seen, 0);
      run_to_done(d2, n);
      check("s6_recover_latency", n, 18);
      check("s6_recover_ofs", ofs, pack(d2));

      // randomized traffic against the model
      do_reset();
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < NTI; i++) dr[i] = int'($urandom_range(0, 255)) - 128;
         if (k % 300 < 150)
            for (int i = 0; i < NTI; i++) dr[i] = (i * 17 - 30) + int'($urandom_range(0, 6)) - 3;
         step($urandom_range(0, 39) != 0, dr);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
